ptp_a: RTL

// - Input-side partner of the output byte serialiser: rebuilds a 64-bit frame {value_a, value_b} from 8-bit bytes presented on pins.
// - Bytes arrive MSB-first, one per rising edge of the asynchronous pin strobe control_i.
//   The first byte lands in value_a_o[31:24]; the last lands in value_b_o[7:0].
// - A completed frame is handed to the Manchester Baby core (RAM data / address load) through a valid/ready handshake.
//

---
 rtl/ptp_pkg.sv | 13 +
 rtl/pin_sync_edge.sv | 31 +++
 rtl/ptp_a.sv | 99 +++++++++
 3 files changed

// File: rtl/ptp_pkg.sv
// Shared widths and FSM state type for the pin-side byte deserialiser.
package ptp_pkg;

  localparam int PTP_BYTE_W  = 8;
  localparam int PTP_WORD_W  = 32;
  localparam int PTP_FRAME_W = 64;

  typedef enum logic {
    PTP_FILL = 1'b0,
    PTP_FULL = 1'b1
  } ptp_state_t;

endpackage

// File: rtl/pin_sync_edge.sv
// Multi-flop synchroniser for an asynchronous pin, followed by a rising-edge
// detect that produces a single-cycle pulse in the clk_i domain.
module pin_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic pin_i,
  output logic rise_o
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;

  // Everything resets high so a pin already high at reset release reads as
  // "no edge" rather than a spurious capture.
  // NOTE: sequential state uses non-blocking assignments only; mixing in
  // blocking writes here would make simulation order-dependent.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '1;
      hist_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      hist_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise_o = sync_q[SYNC_STAGES-1] & ~hist_q;

endmodule

// File: rtl/ptp_a.sv
// Rebuilds a 32- or 64-bit frame from pin-strobed bytes (MSB first) and hands
// it to the core over a valid/ready handshake, flagging bytes lost to overrun.
module ptp_a
  import ptp_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FRAME_BYTES = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        control_i,
  input  logic [7:0]  byte_i,
  input  logic        clear_i,
  input  logic        ready_i,
  output logic        valid_o,
  output logic [31:0] value_a_o,
  output logic [31:0] value_b_o,
  output logic [2:0]  count_o,
  output logic        overrun_o
);

  localparam logic [2:0] LAST_IDX = 3'(FRAME_BYTES - 1);

  ptp_state_t             state_q, state_d;
  logic                   strobe;
  logic                   capture;
  logic                   frame_done;
  logic [PTP_FRAME_W-1:0] shift_q;
  logic [2:0]             count_q;
  logic                   overrun_q;

  pin_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_pin_sync_edge (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .pin_i   (control_i),
    .rise_o  (strobe)
  );

  // A byte is taken while filling, or in FULL only when the handshake
  // completes in the same cycle so the byte starts the next frame.
  // NOTE: every combinational output gets a value on every path so no latch
  // is inferred.
  always_comb begin
    capture    = strobe & ~clear_i & ((state_q == PTP_FILL) | ready_i);
    frame_done = capture & (state_q == PTP_FILL) & (count_q == LAST_IDX);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= PTP_FILL;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (clear_i) begin
      state_d = PTP_FILL;
    end else begin
      case (state_q)
        PTP_FILL: if (frame_done) state_d = PTP_FULL;
        PTP_FULL: if (ready_i)    state_d = PTP_FILL;
        default:                  state_d = PTP_FILL;
      endcase
    end
  end

  always_comb begin
    valid_o = (state_q == PTP_FULL);
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      shift_q   <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else if (clear_i) begin
      shift_q   <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      if (capture) begin
        shift_q <= {shift_q[PTP_FRAME_W-PTP_BYTE_W-1:0], byte_i};
        if (state_q == PTP_FULL)     count_q <= 3'd1;
        else if (count_q == LAST_IDX) count_q <= '0;
        else                          count_q <= count_q + 3'd1;
      end
      if (strobe && (state_q == PTP_FULL) && !ready_i) overrun_q <= 1'b1;
    end
  end

  // A 4-byte frame lives entirely in the low word of the shift register.
  assign value_a_o = (FRAME_BYTES == 4) ? shift_q[PTP_WORD_W-1:0]
                                        : shift_q[PTP_FRAME_W-1:PTP_WORD_W];
  assign value_b_o = (FRAME_BYTES == 4) ? '0 : shift_q[PTP_WORD_W-1:0];
  assign count_o   = count_q;
  assign overrun_o = overrun_q;

endmodule
